// File: rtl/lsu_stage.sv
// Load/store stage between EX and writeback: it passes ALU results through, or it issues
// one memory request and waits for mem_ack before it writes back.
module lsu_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] StoreData,
  input  logic [2:0]            Funct3,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  RegWrite,
  input  logic [4:0]            rd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  mem_err,
  output logic                  dbg_state
);

  // Handshakes: an EX instruction transfers on a cycle where ex_valid && ex_ready.
  // The memory request transfers on the cycle where mem_req && mem_ack. The request
  // fields stay frozen while mem_req is high. An ack that arrives while mem_req is low
  // has no effect.
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_we_q, wb_we_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  mem_err_q, mem_err_d;
  logic                  is_load_q, is_load_d;
  logic                  regwrite_q, regwrite_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [4:0]            rd_q, rd_d;

  logic                  is_mem, is_load, legal, misaligned;
  logic [1:0]            size, off;
  logic [3:0]            be_dec;
  logic [DATA_WIDTH-1:0] wdata_dec;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_val;

  assign is_mem  = MemRead | MemWrite;
  assign is_load = MemRead;
  assign size    = Funct3[1:0];
  assign off     = ALUResult[1:0];
  // Size code 11 is never legal. Bit 2 (unsigned) is legal only for LBU/LHU.
  assign legal      = (size != 2'b11) && (!Funct3[2] || (is_load && (size != 2'b10)));
  assign misaligned = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));

  always_comb begin
    be_dec    = 4'b1111;
    wdata_dec = StoreData;
    case (size)
      2'b00: begin
        be_dec    = 4'b0001 << off;
        wdata_dec = {(DATA_WIDTH/8){StoreData[7:0]}};
      end
      2'b01: begin
        be_dec    = 4'b0011 << off;
        wdata_dec = {(DATA_WIDTH/16){StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off_q)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_val = f3_q[2] ? {{(DATA_WIDTH-8){1'b0}}, ld_byte}
                                : {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = f3_q[2] ? {{(DATA_WIDTH-16){1'b0}}, ld_half}
                                : {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    mem_err_d   = 1'b0;
    is_load_d   = is_load_q;
    regwrite_d  = regwrite_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = RegWrite;
            wb_rd_d    = rd;
            wb_data_d  = ALUResult;
          end else if (!legal || misaligned) begin
            mem_err_d = 1'b1;
          end else begin
            state_d     = WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = !is_load;
            mem_addr_d  = {ALUResult[DATA_WIDTH-1:2], 2'b00};
            mem_wdata_d = wdata_dec;
            mem_be_d    = be_dec;
            is_load_d   = is_load;
            regwrite_d  = RegWrite;
            f3_d        = Funct3;
            off_d       = off;
            rd_d        = rd;
          end
        end
      end
      WAIT: begin
        // mem_req is always high in WAIT, so the ack is sampled only here.
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_be_d   = 4'b0000;
          wb_valid_d = 1'b1;
          wb_we_d    = is_load_q & regwrite_q;
          wb_rd_d    = rd_q;
          wb_data_d  = is_load_q ? ld_val : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
      mem_err_q   <= 1'b0;
      is_load_q   <= 1'b0;
      regwrite_q  <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      rd_q        <= 5'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      mem_err_q   <= mem_err_d;
      is_load_q   <= is_load_d;
      regwrite_q  <= regwrite_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
    end
  end

  assign ex_ready  = (state_q == IDLE);
  assign dbg_state = state_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: directed scenarios plus randomized instructions checked against an
// arithmetic reference model of the load/store rules.
module tb_lsu_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, ex_valid, ex_ready;
  logic [W-1:0] ALUResult, StoreData, mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [2:0]   Funct3;
  logic         MemRead, MemWrite, RegWrite, mem_req, mem_we, mem_ack;
  logic         wb_valid, wb_we, mem_err, dbg_state;
  logic [4:0]   rd, wb_rd;
  logic [3:0]   mem_be;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_stage #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ALUResult(ALUResult), .StoreData(StoreData), .Funct3(Funct3),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_err(mem_err), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, limit 600000 expected end before it");
    $fatal(1);
  end

  typedef struct {
    logic         accepted, timeout, req_seen, unstable, ready_hi_in_wait;
    logic         ready_at_wb, ready_at_err, we, wb_we;
    logic [W-1:0] addr, wdata, wb_data;
    logic [3:0]   be;
    logic [4:0]   wb_rd;
    int           wb_cnt, wb_cycle, err_cnt, err_cycle;
  } obs_t;

  typedef struct {
    int           kind;  // 0 pass-through, 1 error, 2 memory access
    logic [W-1:0] addr, wdata, wb_data;
    logic [3:0]   be;
    logic         we, wb_we;
  } exp_t;

  // Reference model: built from byte counts and offsets, not from the RTL's slices
  function automatic exp_t ref_model(logic [W-1:0] alu, logic [W-1:0] sd, logic [2:0] f3,
                                     logic mr, logic mw, logic rw, logic [W-1:0] rdata);
    exp_t e;
    int nbytes, off;
    bit legal;
    logic [W-1:0] mask, v;
    e = '{default: 0};
    if (!(mr || mw)) begin
      e.kind = 0; e.wb_data = alu; e.wb_we = rw;
      return e;
    end
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal  = mr ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    off    = int'(alu[1:0]);
    if (!legal || (off % nbytes) != 0) begin
      e.kind = 1;
      return e;
    end
    e.kind  = 2;
    e.addr  = alu - W'(off);
    e.be    = 4'(((1 << nbytes) - 1) << off);
    e.we    = !mr;
    mask    = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 32'd1;
    e.wdata = (nbytes == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
              (nbytes == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
    if (mr) begin
      v = (rdata >> (8 * off)) & mask;
      if (!f3[2] && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
      e.wb_data = v;
      e.wb_we   = rw;
    end
    return e;
  endfunction

  // Driver: presents one instruction, acks after ack_delay request cycles, records outputs
  task automatic do_instr(input logic [W-1:0] alu, input logic [W-1:0] sd, input logic [2:0] f3,
                          input logic mr, input logic mw, input logic rw, input logic [4:0] rdi,
                          input int ack_delay, input logic [W-1:0] rdata, output obs_t o);
    int cyc, waited, idle_after;
    o = '{default: 0};
    @(negedge clk);
    o.accepted = ex_ready;
    ex_valid = 1'b1; ALUResult = alu; StoreData = sd; Funct3 = f3;
    MemRead = mr; MemWrite = mw; RegWrite = rw; rd = rdi;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    cyc = 1; waited = 0; idle_after = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      cyc++;
      ex_valid = 1'b0; ALUResult = $urandom; StoreData = $urandom; Funct3 = 3'($urandom);
      MemRead = 1'($urandom); MemWrite = 1'($urandom); RegWrite = 1'($urandom); rd = 5'($urandom);
      if (wb_valid) begin
        o.wb_cnt++;
        if (o.wb_cnt == 1) begin
          o.wb_cycle = cyc; o.wb_data = wb_data; o.wb_we = wb_we; o.wb_rd = wb_rd;
          o.ready_at_wb = ex_ready;
        end
      end
      if (mem_err) begin
        o.err_cnt++; o.err_cycle = cyc; o.ready_at_err = ex_ready;
      end
      if (mem_req) begin
        if (!o.req_seen) begin
          o.req_seen = 1'b1; o.addr = mem_addr; o.wdata = mem_wdata; o.be = mem_be; o.we = mem_we;
        end else if (mem_addr !== o.addr || mem_wdata !== o.wdata || mem_be !== o.be || mem_we !== o.we) begin
          o.unstable = 1'b1;
        end
        if (ex_ready) o.ready_hi_in_wait = 1'b1;
        if (waited == ack_delay) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
        waited++;
      end else begin
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      end
      if ((o.wb_cnt > 0 || o.err_cnt > 0) && !mem_req && idle_after < 0) idle_after = cyc;
      if (idle_after >= 0 && cyc >= idle_after + 2) break;
    end
    if (idle_after < 0) o.timeout = 1'b1;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_valid = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b expected 1", ex_ready); end
    n_cmp++; if ({mem_req, mem_we, mem_be, wb_valid, wb_we, mem_err} !== 9'd0) begin
      n_bad++; $display("FAIL rst_ctrl: got %b expected 0", {mem_req, mem_we, mem_be, wb_valid, wb_we, mem_err}); end
    n_cmp++; if ({mem_addr, mem_wdata, wb_data, wb_rd} !== 101'd0) begin
      n_bad++; $display("FAIL rst_data: got %h %h %h %h expected all 0", mem_addr, mem_wdata, wb_data, wb_rd); end
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    obs_t o;
    do_instr(32'h0000_1234, $urandom, 3'($urandom), 1'b0, 1'b0, 1'b1, 5'd5, 0, $urandom, o);
    n_cmp++; if (o.wb_cnt !== 1 || o.wb_cycle !== 2) begin
      n_bad++; $display("FAIL pt_timing: got cnt %0d cycle %0d expected cnt 1 cycle 2", o.wb_cnt, o.wb_cycle); end
    n_cmp++; if ({o.wb_data, o.wb_rd, o.wb_we} !== {32'h0000_1234, 5'd5, 1'b1}) begin
      n_bad++; $display("FAIL pt_wb: got %h rd %0d we %b expected 00001234 rd 5 we 1", o.wb_data, o.wb_rd, o.wb_we); end
    n_cmp++; if (o.req_seen !== 1'b0 || o.accepted !== 1'b1) begin
      n_bad++; $display("FAIL pt_noreq: got req %b acc %b expected req 0 acc 1", o.req_seen, o.accepted); end
    do_instr(32'hDEAD_BEEF, 0, 3'd2, 1'b0, 1'b0, 1'b0, 5'd9, 0, 0, o);
    n_cmp++; if (o.wb_we !== 1'b0 || o.wb_data !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL pt_nowe: got we %b data %h expected we 0 data deadbeef", o.wb_we, o.wb_data); end
  endtask

  task automatic test_lb_sign();
    obs_t o;
    do_instr(32'h0000_0103, 0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd7, 2, 32'h8012_3456, o);
    n_cmp++; if ({o.addr, o.be, o.we} !== {32'h100, 4'b1000, 1'b0}) begin
      n_bad++; $display("FAIL lb_req: got %h be %b we %b expected 100 be 1000 we 0", o.addr, o.be, o.we); end
    n_cmp++; if (o.ready_hi_in_wait !== 1'b0 || o.unstable !== 1'b0) begin
      n_bad++; $display("FAIL lb_wait: got ready_hi %b unstable %b expected 0 0", o.ready_hi_in_wait, o.unstable); end
    n_cmp++; if ({o.wb_data, o.wb_we, o.wb_rd} !== {32'hFFFF_FF80, 1'b1, 5'd7}) begin
      n_bad++; $display("FAIL lb_wb: got %h we %b rd %0d expected ffffff80 we 1 rd 7", o.wb_data, o.wb_we, o.wb_rd); end
    n_cmp++; if (o.wb_cycle !== 5 || o.wb_cnt !== 1) begin
      n_bad++; $display("FAIL lb_lat: got cycle %0d cnt %0d expected 5 1", o.wb_cycle, o.wb_cnt); end
  endtask

  task automatic test_lhu();
    obs_t o;
    do_instr(32'h0000_0202, 0, 3'b101, 1'b1, 1'b0, 1'b1, 5'd12, 0, 32'hBEEF_0000, o);
    n_cmp++; if (o.wb_data !== 32'h0000_BEEF) begin
      n_bad++; $display("FAIL lhu_data: got %h expected 0000beef", o.wb_data); end
    n_cmp++; if (o.wb_cycle !== 3 || o.ready_at_wb !== 1'b1) begin
      n_bad++; $display("FAIL lhu_lat: got cycle %0d ready %b expected 3 1", o.wb_cycle, o.ready_at_wb); end
    n_cmp++; if ({o.addr, o.be} !== {32'h200, 4'b1100}) begin
      n_bad++; $display("FAIL lhu_req: got %h be %b expected 200 be 1100", o.addr, o.be); end
  endtask

  task automatic test_sb();
    obs_t o;
    do_instr(32'h0000_0005, 32'h1234_56AB, 3'b000, 1'b0, 1'b1, 1'b1, 5'd3, 1, $urandom, o);
    n_cmp++; if ({o.we, o.be, o.wdata, o.addr} !== {1'b1, 4'b0010, 32'hABAB_ABAB, 32'h4}) begin
      n_bad++; $display("FAIL sb_req: got we %b be %b wdata %h addr %h expected 1 0010 abababab 4", o.we, o.be, o.wdata, o.addr); end
    n_cmp++; if ({o.wb_cnt, o.wb_we, o.wb_data, o.wb_rd} !== {32'd1, 1'b0, 32'd0, 5'd3}) begin
      n_bad++; $display("FAIL sb_wb: got cnt %0d we %b data %h rd %0d expected 1 0 0 3", o.wb_cnt, o.wb_we, o.wb_data, o.wb_rd); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    do_instr(32'h0000_0006, 0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd4, 0, 0, o);
    n_cmp++; if (o.err_cnt !== 1 || o.err_cycle !== 2 || o.ready_at_err !== 1'b1) begin
      n_bad++; $display("FAIL mis_err: got cnt %0d cycle %0d ready %b expected 1 2 1", o.err_cnt, o.err_cycle, o.ready_at_err); end
    n_cmp++; if (o.req_seen !== 1'b0 || o.wb_cnt !== 0) begin
      n_bad++; $display("FAIL mis_quiet: got req %b wb %0d expected 0 0", o.req_seen, o.wb_cnt); end
    do_instr(32'h0000_0010, 0, 3'b100, 1'b0, 1'b1, 1'b0, 5'd4, 0, 0, o);
    n_cmp++; if (o.err_cnt !== 1 || o.req_seen !== 1'b0) begin
      n_bad++; $display("FAIL ill_store: got err %0d req %b expected 1 0", o.err_cnt, o.req_seen); end
  endtask

  task automatic test_spurious_ack();
    int hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wb_valid || mem_err || mem_req || wb_we) hits++;
      ex_valid = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
    end
    @(negedge clk);
    if (wb_valid || mem_err || mem_req || wb_we) hits++;
    mem_ack = 1'b0;
    n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL idle_ack: got %0d active cycles expected 0", hits); end
  endtask

  task automatic test_reset_in_wait();
    obs_t o;
    int hits = 0;
    @(negedge clk);
    ex_valid = 1'b1; ALUResult = 32'h40; Funct3 = 3'b010; MemRead = 1'b1; MemWrite = 1'b0;
    RegWrite = 1'b1; rd = 5'd8; mem_ack = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    n_cmp++; if ({mem_req, dbg_state, ex_ready} !== 3'b110) begin
      n_bad++; $display("FAIL rw_wait: got req/state/ready %b expected 110", {mem_req, dbg_state, ex_ready}); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mem_req, wb_valid, ex_ready, mem_be, mem_addr} !== {3'b001, 4'b0, 32'h0}) begin
      n_bad++; $display("FAIL rw_abort: got req %b wb %b ready %b be %b addr %h expected 0 0 1 0 0",
                        mem_req, wb_valid, ex_ready, mem_be, mem_addr); end
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_valid || mem_req || !ex_ready) hits++;
    end
    mem_ack = 1'b0;
    n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL rw_late_ack: got %0d bad cycles expected 0", hits); end
    do_instr(32'h0000_0044, 0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd9, 1, 32'hCAFE_F00D, o);
    n_cmp++; if ({o.wb_cnt, o.wb_data, o.wb_rd} !== {32'd1, 32'hCAFE_F00D, 5'd9}) begin
      n_bad++; $display("FAIL rw_next: got cnt %0d data %h rd %0d expected 1 cafef00d 9", o.wb_cnt, o.wb_data, o.wb_rd); end
  endtask

  task automatic test_back_to_back();
    logic [W+5:0] exp_q[$];
    logic [W+5:0] exp;
    logic [W-1:0] a;
    logic [4:0]   r;
    logic         w;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = exp_q.pop_front();
        n_cmp++; if ({wb_valid, wb_we, wb_rd, wb_data} !== {1'b1, exp}) begin
          n_bad++; $display("FAIL b2b_wb%0d: got %b %b %0d %h expected 1 %b %0d %h", i,
                            wb_valid, wb_we, wb_rd, wb_data, exp[W+5], exp[W+4:W], exp[W-1:0]); end
      end
      if (i < 8) begin
        n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d: got 0 expected 1", i); end
        a = $urandom; r = 5'($urandom); w = 1'($urandom);
        ex_valid = 1'b1; ALUResult = a; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = w; rd = r;
        exp_q.push_back({w, r, a});
      end else begin
        ex_valid = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [W-1:0] alu, sd, rdata;
    logic [2:0] f3;
    logic mr, mw, rw;
    logic [4:0] r;
    int d;
    for (int i = 0; i < 80; i++) begin
      alu = $urandom; sd = $urandom; rdata = $urandom; f3 = 3'($urandom);
      mr = 1'($urandom); mw = 1'($urandom); rw = 1'($urandom); r = 5'($urandom);
      d = $urandom_range(0, 3);
      e = ref_model(alu, sd, f3, mr, mw, rw, rdata);
      do_instr(alu, sd, f3, mr, mw, rw, r, d, rdata, o);
      n_cmp++; if (o.timeout !== 1'b0 || o.accepted !== 1'b1) begin
        n_bad++; $display("FAIL rnd%0d_done: got timeout %b acc %b expected 0 1", i, o.timeout, o.accepted); end
      if (e.kind == 1) begin
        n_cmp++; if (o.err_cnt !== 1 || o.err_cycle !== 2 || o.wb_cnt !== 0 || o.req_seen !== 1'b0) begin
          n_bad++; $display("FAIL rnd%0d_err: got err %0d@%0d wb %0d req %b expected 1@2 0 0",
                            i, o.err_cnt, o.err_cycle, o.wb_cnt, o.req_seen); end
      end else begin
        n_cmp++; if (o.wb_cnt !== 1 || o.err_cnt !== 0 || o.wb_cycle !== ((e.kind == 0) ? 2 : 3 + d)) begin
          n_bad++; $display("FAIL rnd%0d_lat: got wb %0d@%0d err %0d expected 1@%0d 0",
                            i, o.wb_cnt, o.wb_cycle, o.err_cnt, (e.kind == 0) ? 2 : 3 + d); end
        n_cmp++; if ({o.wb_data, o.wb_we, o.wb_rd} !== {e.wb_data, e.wb_we, r}) begin
          n_bad++; $display("FAIL rnd%0d_wb: got %h we %b rd %0d expected %h we %b rd %0d",
                            i, o.wb_data, o.wb_we, o.wb_rd, e.wb_data, e.wb_we, r); end
        if (e.kind == 2) begin
          n_cmp++; if ({o.req_seen, o.addr, o.be, o.we, o.unstable, o.ready_hi_in_wait} !==
                       {1'b1, e.addr, e.be, e.we, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL rnd%0d_req: got %b %h %b %b %b %b expected 1 %h %b %b 0 0", i,
                              o.req_seen, o.addr, o.be, o.we, o.unstable, o.ready_hi_in_wait, e.addr, e.be, e.we); end
          if (e.we) begin
            n_cmp++; if (o.wdata !== e.wdata) begin
              n_bad++; $display("FAIL rnd%0d_wdata: got %h expected %h", i, o.wdata, e.wdata); end
          end
        end else begin
          n_cmp++; if (o.req_seen !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_noreq: got 1 expected 0", i); end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ALUResult = '0; StoreData = '0; Funct3 = 3'd0;
    MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; rd = 5'd0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_passthrough();
    test_lb_sign();
    test_lhu();
    test_sb();
    test_misaligned();
    test_spurious_ack();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
